// File: rtl/fish_sprite_engine_if.sv
// Sprite ROM address/data bus between the fish engine (master) and the 32x16 sprite ROM (slave).
// Latency: ROM returns rom_data one clk after rom_row/rom_col. Backpressure: none, the ROM is always ready.
// The interface only groups the address and data wires; it holds no state.
interface fish_sprite_engine_if;
    logic [3:0]  rom_row;
    logic [4:0]  rom_col;
    logic [11:0] rom_data;

    modport master (output rom_row, output rom_col, input rom_data);
    modport slave  (input rom_row, input rom_col, output rom_data);
endinterface

// File: rtl/fish_sprite_engine.sv
// Fish sprite engine: hit test, mirrored ROM addressing, colour keying, and a frame-tick swim FSM. Optional FISH_BOB_EN adds vertical bob.
// Latency: 2 clk from x/y to fish_on/rgb_out. Position moves only on frame_tick.
// Backpressure: none. Pixels stream every clk, and the ROM answers a fixed one cycle later.
module fish_sprite_engine #(
    parameter int          SPRITE_W  = 32,
    parameter int          SPRITE_H  = 16,
    parameter int          H_MAX     = 640,
    parameter int          X_START   = 100,
    parameter int          Y_START   = 200,
    parameter int          SPEED     = 1,
    parameter logic [11:0] KEY_COLOR = 12'h0F0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        video_on,
    input  logic [9:0]                  x,
    input  logic [9:0]                  y,
    input  logic                        frame_tick,
    input  logic                        enable,
    input  logic                        caught,
    fish_sprite_engine_if.master        rom,
    output logic                        fish_on,
    output logic [11:0]                 rgb_out,
    output logic [9:0]                  fish_x,
    output logic [9:0]                  fish_y,
    output logic                        dir
);
    localparam int X_MAX = H_MAX - SPRITE_W;

    typedef enum logic [1:0] {IDLE, SWIM_R, SWIM_L, HOOKED} state_t;

    state_t      state, state_nxt;
    logic [9:0]  x_nxt;
    logic        dir_nxt;
    logic        swim_move;
    logic        hit;
    logic        hit_d, von_d;
    logic        pix_on;
    logic [10:0] x_end, y_end;
    logic [4:0]  dx;
    logic [3:0]  dy;

    // Hit test is done in 11 bits so a sprite near the right/bottom edge never wraps.
    always_comb begin
        x_end = {1'b0, fish_x} + 11'(SPRITE_W);
        y_end = {1'b0, fish_y} + 11'(SPRITE_H);
        hit   = (x >= fish_x) && ({1'b0, x} < x_end) &&
                (y >= fish_y) && ({1'b0, y} < y_end);
        dx    = x[4:0] - fish_x[4:0];
        dy    = y[3:0] - fish_y[3:0];
    end

    always_comb begin
        rom.rom_row = 4'd0;
        rom.rom_col = 5'd0;
        if (hit) begin
            rom.rom_row = dy;
            rom.rom_col = dir ? dx : (5'(SPRITE_W - 1) - dx);
        end
    end

    assign pix_on = hit_d && von_d && (rom.rom_data != KEY_COLOR);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_d   <= 1'b0;
            von_d   <= 1'b0;
            fish_on <= 1'b0;
            rgb_out <= 12'd0;
        end else begin
            hit_d   <= hit;
            von_d   <= video_on;
            fish_on <= pix_on;
            rgb_out <= pix_on ? rom.rom_data : 12'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            fish_x <= 10'(X_START);
            dir    <= 1'b1;
        end else begin
            state  <= state_nxt;
            fish_x <= x_nxt;
            dir    <= dir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = fish_x;
        dir_nxt   = dir;
        case (state)
            IDLE: begin
                if (frame_tick && enable) begin
                    state_nxt = SWIM_R;
                    dir_nxt   = 1'b1;
                end
            end
            SWIM_R: begin
                if (caught) begin
                    state_nxt = HOOKED;
                end else if (swim_move) begin
                    if (fish_x >= 10'(X_MAX - SPEED)) begin
                        x_nxt     = 10'(X_MAX);
                        dir_nxt   = 1'b0;
                        state_nxt = SWIM_L;
                    end else begin
                        x_nxt = fish_x + 10'(SPEED);
                    end
                end
            end
            SWIM_L: begin
                if (caught) begin
                    state_nxt = HOOKED;
                end else if (swim_move) begin
                    if (fish_x <= 10'(SPEED)) begin
                        x_nxt     = 10'd0;
                        dir_nxt   = 1'b1;
                        state_nxt = SWIM_R;
                    end else begin
                        x_nxt = fish_x - 10'(SPEED);
                    end
                end
            end
            HOOKED: begin
                if (frame_tick && !caught)
                    state_nxt = dir ? SWIM_R : SWIM_L;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        swim_move = frame_tick && enable && !caught &&
                    ((state == SWIM_R) || (state == SWIM_L));
    end

`ifdef FISH_BOB_EN
    logic [2:0]        bob_cnt;
    logic signed [2:0] bob_off, bob_step;
    logic              bob_up;

    assign bob_step = bob_up ? (bob_off - 3'sd1) : (bob_off + 3'sd1);

    // Bob only advances on ticks that actually move the fish, so it freezes in IDLE/HOOKED.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bob_cnt <= 3'd0;
            bob_off <= 3'sd0;
            bob_up  <= 1'b1;
        end else if (swim_move) begin
            bob_cnt <= bob_cnt + 3'd1;
            if (bob_cnt == 3'd7) begin
                bob_off <= bob_step;
                if (bob_step == -3'sd2)
                    bob_up <= 1'b0;
                else if (bob_step == 3'sd2)
                    bob_up <= 1'b1;
            end
        end
    end

    assign fish_y = 10'(Y_START) + {{7{bob_off[2]}}, bob_off};
`else
    assign fish_y = 10'(Y_START);
`endif

endmodule

// File: tb/tb_fish_sprite_engine.sv
// Directed bench for fish_sprite_engine: reset, pixel pipeline, mirroring, edge bounces, hooked freeze, mid-run reset.
module tb_fish_sprite_engine;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        video_on;
    logic [9:0]  x, y;
    logic        frame_tick;
    logic        enable;
    logic        caught;
    logic        fish_on;
    logic [11:0] rgb_out;
    logic [9:0]  fish_x, fish_y;
    logic        dir;
    int          n_cmp = 0;
    int          n_bad = 0;

    fish_sprite_engine_if rom_bus ();

    fish_sprite_engine dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .video_on  (video_on),
        .x         (x),
        .y         (y),
        .frame_tick(frame_tick),
        .enable    (enable),
        .caught    (caught),
        .rom       (rom_bus.master),
        .fish_on   (fish_on),
        .rgb_out   (rgb_out),
        .fish_x    (fish_x),
        .fish_y    (fish_y),
        .dir       (dir)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic en, input logic c);
        @(negedge clk);
        frame_tick = 1'b1;
        enable     = en;
        caught     = c;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
    endtask

    task automatic pix(input string tag, input logic [9:0] px, input logic [9:0] py,
                       input logic von, input logic [11:0] rdat,
                       input logic [3:0] er, input logic [4:0] ec,
                       input logic eon, input logic [11:0] ergb);
        @(negedge clk);
        x = px; y = py; video_on = von;
        #1;
        chk({tag, "_row"}, 12'(rom_bus.rom_row), 12'(er));
        chk({tag, "_col"}, 12'(rom_bus.rom_col), 12'(ec));
        @(posedge clk);
        #1;
        rom_bus.rom_data = rdat;
        x = 10'd0; y = 10'd0;
        @(posedge clk);
        #1;
        chk({tag, "_on"},  12'(fish_on), 12'(eon));
        chk({tag, "_rgb"}, rgb_out, ergb);
    endtask

    initial begin
        reset_n = 1'b0; video_on = 1'b0; x = 10'd0; y = 10'd0;
        frame_tick = 1'b0; enable = 1'b0; caught = 1'b0;
        rom_bus.rom_data = 12'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst_x",   12'(fish_x),  12'd100);
        chk("rst_y",   12'(fish_y),  12'd200);
        chk("rst_dir", 12'(dir),     12'd1);
        chk("rst_on",  12'(fish_on), 12'd0);
        chk("rst_rgb", rgb_out,      12'd0);
        tick(1'b0, 1'b0);
        chk("noen_x", 12'(fish_x), 12'd100);

        pix("p_opaque", 10'd105, 10'd203, 1'b1, 12'hF00, 4'd3, 5'd5, 1'b1, 12'hF00);
        pix("p_key",    10'd105, 10'd203, 1'b1, 12'h0F0, 4'd3, 5'd5, 1'b0, 12'h000);
        pix("p_blank",  10'd105, 10'd203, 1'b0, 12'hF00, 4'd3, 5'd5, 1'b0, 12'h000);
        pix("p_last",   10'd131, 10'd215, 1'b1, 12'h00F, 4'd15, 5'd31, 1'b1, 12'h00F);

        tick(1'b1, 1'b0);
        chk("idle_go_x", 12'(fish_x), 12'd100);
        tick(1'b1, 1'b0);
        chk("swim_r_x", 12'(fish_x), 12'd101);
        tick(1'b0, 1'b0);
        chk("hold_x", 12'(fish_x), 12'd101);

        ticks(505);
        chk("r606_x", 12'(fish_x), 12'd606);
        tick(1'b1, 1'b0);
        chk("r607_x", 12'(fish_x), 12'd607);
        chk("r607_dir", 12'(dir), 12'd1);
        tick(1'b1, 1'b0);
        chk("rbounce_x",   12'(fish_x), 12'd608);
        chk("rbounce_dir", 12'(dir),    12'd0);
        tick(1'b1, 1'b0);
        chk("rback_x", 12'(fish_x), 12'd607);

        ticks(307);
        chk("l300_x", 12'(fish_x), 12'd300);
        tick(1'b1, 1'b1);
        chk("hook_x", 12'(fish_x), 12'd300);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        chk("hooked_x", 12'(fish_x), 12'd300);
        tick(1'b1, 1'b0);
        chk("unhook_x",   12'(fish_x), 12'd300);
        chk("unhook_dir", 12'(dir),    12'd0);
        tick(1'b1, 1'b0);
        chk("after_hook_x", 12'(fish_x), 12'd299);

        @(negedge clk);
        caught = 1'b1;
        @(negedge clk);
        caught = 1'b0;
        tick(1'b1, 1'b0);
        chk("pulse_hook_x", 12'(fish_x), 12'd299);
        tick(1'b1, 1'b0);
        chk("pulse_resume_x", 12'(fish_x), 12'd298);

        ticks(198);
        chk("l100_x", 12'(fish_x), 12'd100);
        pix("m_in",   10'd105, 10'd203, 1'b1, 12'hF00, 4'd3, 5'd26, 1'b1, 12'hF00);
        pix("m_left", 10'd99,  10'd203, 1'b1, 12'hF00, 4'd0, 5'd0,  1'b0, 12'h000);
        pix("m_right",10'd132, 10'd203, 1'b1, 12'hF00, 4'd0, 5'd0,  1'b0, 12'h000);
        pix("m_below",10'd105, 10'd216, 1'b1, 12'hF00, 4'd0, 5'd0,  1'b0, 12'h000);

        ticks(98);
        chk("l2_x", 12'(fish_x), 12'd2);
        tick(1'b1, 1'b0);
        chk("l1_x", 12'(fish_x), 12'd1);
        tick(1'b1, 1'b0);
        chk("lbounce_x",   12'(fish_x), 12'd0);
        chk("lbounce_dir", 12'(dir),    12'd1);
        tick(1'b1, 1'b0);
        chk("lback_x", 12'(fish_x), 12'd1);

        @(negedge clk);
        x = 10'd3; y = 10'd203; video_on = 1'b1; rom_bus.rom_data = 12'hF00;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_x",   12'(fish_x),  12'd100);
        chk("mrst_dir", 12'(dir),     12'd1);
        chk("mrst_on0", 12'(fish_on), 12'd0);
        @(negedge clk);
        reset_n = 1'b1; x = 10'd0; y = 10'd0;
        @(posedge clk);
        #1;
        chk("mrst_on1", 12'(fish_on), 12'd0);
        @(posedge clk);
        #1;
        chk("mrst_on2", 12'(fish_on), 12'd0);
        chk("mrst_rgb", rgb_out,      12'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
